data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//  - Byte-addressable, little-endian RV32 data memory for the single-cycle datapath (MEM stage).
//  - Supports LB/LH/LW/LBU/LHU loads with sign/zero extension and SB/SH/SW stores.
//  - Reads are combinational; writes commit on the rising clock edge.
// PARAMETERS
//  - DEPTH_WORDS  1024  number of 32-bit words; must be a power of 2; size = 4*DEPTH_WORDS bytes
// PORTS
//  - clk      in   1   single clock; all state updates on posedge
//  - rst      in   1   reset, synchronous, active-high
//  - Address  in   32  byte address from ALU
//  - DataWr   in   32  store data; low byte/half/word used per size
//  - DMWr     in   1   write enable; 1 = store this cycle
//  - DMCtrl   in   3   access type: [1:0] size (00 byte, 01 half, 10 word, 11 none), [2] 1 = unsigned load
//  - DataRd   out  32  load result, combinational
// BEHAVIOUR
//  - Storage: DEPTH_WORDS x 32-bit array. Word index = Address[log2(DEPTH_WORDS)+1:2].
//    - Upper address bits are ignored, so addresses wrap modulo the memory size.
//  - Reset: when rst=1 at a posedge, every word clears to 0. Reset wins over a simultaneous write.
//    - DataRd is then 0 for every address and every DMCtrl value.
//  - Write: at posedge with rst=0 and DMWr=1:
//    - SB (size 00): byte lane Address[1:0] <= DataWr[7:0].
//    - SH (size 01): bytes Address[1]*2 and Address[1]*2+1 <= DataWr[15:0], little-endian. Address[0] ignored.
//    - SW (size 10): whole word <= DataWr. Address[1:0] ignored.
//    - Size 11: no write. DMCtrl[2] is ignored for stores.
//    - Unselected byte lanes keep their values.
//  - Read (combinational, independent of DMWr):
//    - LB  000 -> sign-extend byte Address[1:0].
//    - LH  001 -> sign-extend half Address[1].
//    - LW  010 -> full word.
//    - LBU 100 -> zero-extend byte.
//    - LHU 101 -> zero-extend half.
//    - 110 -> full word. 011, 111 -> 32'h0.
//  - Read-during-write: DataRd shows the old contents until the edge, then the new data.
//    - No bypass of DataWr.
//  - Timing: no latency on reads; stores become visible immediately after the committing edge.
// CONFIGURATION
//  - Macro DMEM_MISALIGN_CHECK_EN.
//  - Defined:
//    - Adds output port misaligned (1 bit, combinational).
//    - misaligned is high when (size 01 and Address[0]) or (size 10 and Address[1:0]!=0).
//    - While misaligned is high, the write is suppressed and DataRd = 32'h0.
//  - Undefined:
//    - No extra port.
//    - Misaligned low address bits are silently ignored as described above.
// STRUCTURE
//  - Shared package dmem_pkg:
//    - typedef enum logic [2:0] dmem_ctrl_e {LB=0, LH=1, LW=2, LBU=4, LHU=5}
//    - localparams SZ_BYTE, SZ_HALF, SZ_WORD, SZ_NONE
//  - Sub-module dmem_load_ext: pure combinational extract and sign/zero-extend from a 32-bit word.
//    - Inputs: word, Address[1:0], DMCtrl. Output: DataRd.
//  - Top holds the array, the byte-enable generation and the sync reset/write process.
// TESTING
//  - Reset: pulse rst 1 cycle, then LW at 0x0, 0x4 and 0xFFC -> 32'h0.
//  - SW 0xDEADBEEF @0x0, clock; LW @0x0 -> 32'hDEADBEEF.
//    - LBU @0x3 -> 32'h000000DE. LB @0x0 -> 32'hFFFFFFEF.
//  - SH 0x0000ABCA @0x8, clock:
//    - LH @0x8 -> 32'hFFFFABCA. LHU @0x8 -> 32'h0000ABCA. LW @0x8 -> 32'h0000ABCA.
//  - SB 0x00000080 @0x10, clock:
//    - LB @0x10 -> 32'hFFFFFF80. LBU @0x10 -> 32'h00000080.
//    - SB 0x55 @0x11, clock; LW @0x10 -> 32'h00005580.
//  - DMWr=1 with rst=1 at the same edge: LW @0x0 -> 32'h0.
//    - DMWr=0 with SW 0x12345678: memory unchanged.
//    - Address 0x1000 with DEPTH 1024 aliases 0x0.
//  - With DMEM_MISALIGN_CHECK_EN: SW @0x2 -> misaligned=1, no write, DataRd=0.
//    - LH @0x9 -> misaligned=1.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared definitions for the RV32 data memory: load/store access codes,
// access-size encodings and the byte-lane helpers used by the top level.
// Optional build macro DMEM_MISALIGN_CHECK_EN enables misalignment detection.
package dmem_pkg;

    // DMCtrl encodings for loads; bit 2 selects zero extension
    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } dmem_ctrl_e;

    // DMCtrl[1:0] access size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_NONE = 2'b11;

    // Byte lanes touched by a store of the given size at the given low address bits
    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Half accesses need an even address, word accesses a multiple of four
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        return ((size == SZ_HALF) && lane[0]) || ((size == SZ_WORD) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// MEM-stage bus between the datapath and the data memory.
// There is no handshake: the datapath presents Address/DMCtrl (and DataWr/DMWr
// for stores) every cycle, DataRd answers combinationally in the same cycle,
// and a store with DMWr=1 commits on the next rising clock edge.
// Optional build macro DMEM_MISALIGN_CHECK_EN adds the misaligned flag.
interface data_memory_if;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic        DMWr;
    logic [2:0]  DMCtrl;
    logic [31:0] DataRd;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        misaligned;
`endif

    modport master (
        output Address, DataWr, DMWr, DMCtrl,
`ifdef DMEM_MISALIGN_CHECK_EN
        input  misaligned,
`endif
        input  DataRd
    );

    modport slave (
        input  Address, DataWr, DMWr, DMCtrl,
`ifdef DMEM_MISALIGN_CHECK_EN
        output misaligned,
`endif
        output DataRd
    );
endinterface

// File: rtl/data_memory_load_ext.sv
// Load formatter: selects the addressed byte or half from a 32-bit memory
// word and sign- or zero-extends it according to DMCtrl. Purely combinational.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  Address,
    input  logic [2:0]  DMCtrl,
    output logic [31:0] DataRd
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed lane and extend it per the access type
    always_comb begin
        sel_byte = '0;
        sel_half = Address[1] ? word[31:16] : word[15:0];
        case (Address)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase

        DataRd = '0;
        case (DMCtrl)
            LB:      DataRd = {{24{sel_byte[7]}}, sel_byte};
            LH:      DataRd = {{16{sel_half[15]}}, sel_half};
            LW:      DataRd = word;
            LBU:     DataRd = {24'h0, sel_byte};
            LHU:     DataRd = {16'h0, sel_half};
            3'b110:  DataRd = word;
            default: DataRd = '0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable little-endian RV32 data memory for the MEM stage.
// Combinational reads, stores commit on posedge, synchronous active-high
// reset clears every word. Addresses wrap modulo 4*DEPTH_WORDS bytes.
// Optional build macro DMEM_MISALIGN_CHECK_EN: flags misaligned half/word
// accesses, suppresses their stores and forces DataRd to zero.
module data_memory
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic          clk,
    input  logic          rst,
    data_memory_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic [1:0]    size;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rd_word;
    logic [31:0]   rd_ext;
    logic          wr_allow;
    logic          unused_addr_bits;

    assign widx             = bus.Address[AW+1:2];
    assign lane             = bus.Address[1:0];
    assign size             = bus.DMCtrl[1:0];
    assign unused_addr_bits = ^{bus.Address[31:AW+2], bus.DMCtrl[2]};

`ifdef DMEM_MISALIGN_CHECK_EN
    logic mis;
    assign mis            = is_misaligned(size, lane);
    assign wr_allow       = ~mis;
    assign bus.misaligned = mis;
    assign bus.DataRd     = mis ? 32'h0 : rd_ext;
`else
    assign wr_allow   = 1'b1;
    assign bus.DataRd = rd_ext;
`endif

    // Replicate store data so each enabled lane finds its bytes in place
    always_comb begin
        be    = byte_enables(size, lane);
        wdata = bus.DataWr;
        case (size)
            SZ_BYTE: wdata = {4{bus.DataWr[7:0]}};
            SZ_HALF: wdata = {2{bus.DataWr[15:0]}};
            default: wdata = bus.DataWr;
        endcase
    end

    // Reset clears the whole array and takes priority over a store
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.DMWr && wr_allow) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[widx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign rd_word = mem[widx];

    dmem_load_ext u_load_ext (
        .word    (rd_word),
        .Address (lane),
        .DMCtrl  (bus.DMCtrl),
        .DataRd  (rd_ext)
    );

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: drivers push hand-computed expectations
// into a queue; a negedge monitor pops and compares whenever a check strobe
// is raised. Misalignment vectors run only when DMEM_MISALIGN_CHECK_EN is set.
module tb_data_memory;

    logic clk = 1'b0;
    logic rst = 1'b1;

    data_memory_if bus ();

    data_memory #(.DEPTH_WORDS(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        exp_mis_q[$];
    logic        strobe = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // Monitor: compare DUT outputs mid-cycle whenever a check is pending
    always @(negedge clk) begin
        if (strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow got=%h", bus.DataRd);
            end else begin
                logic [31:0] e;
                string       n;
                logic        em;
                e  = exp_q.pop_front();
                n  = name_q.pop_front();
                em = exp_mis_q.pop_front();
                checks++;
                if (bus.DataRd !== e) begin
                    errors++;
                    $display("FAIL %s DataRd got=%h exp=%h", n, bus.DataRd, e);
                end
`ifdef DMEM_MISALIGN_CHECK_EN
                checks++;
                if (bus.misaligned !== em) begin
                    errors++;
                    $display("FAIL %s misaligned got=%b exp=%b", n, bus.misaligned, em);
                end
`else
                if (em) begin
                    // misalignment expectations are only queued when the flag exists
                    errors++;
                    $display("FAIL %s unexpected misaligned expectation", n);
                end
`endif
            end
        end
    end

    // Drivers: every task starts and ends just after a rising edge
    task automatic set_bus(input logic [31:0] a, input logic [2:0] c,
                           input logic [31:0] d, input logic we);
        bus.Address = a;
        bus.DMCtrl  = c;
        bus.DataWr  = d;
        bus.DMWr    = we;
    endtask

    task automatic push_exp(input string n, input logic [31:0] e, input logic m);
        exp_q.push_back(e);
        name_q.push_back(n);
        exp_mis_q.push_back(m);
    endtask

    task automatic do_load(input string n, input logic [31:0] a, input logic [2:0] c,
                           input logic [31:0] e, input logic m = 1'b0);
        set_bus(a, c, 32'h0, 1'b0);
        push_exp(n, e, m);
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [2:0] c, input logic [31:0] d);
        set_bus(a, c, d, 1'b1);
        @(posedge clk);
        #1;
        bus.DMWr = 1'b0;
    endtask

    // Store that also checks DataRd/misaligned during the write cycle
    task automatic do_store_chk(input string n, input logic [31:0] a, input logic [2:0] c,
                                input logic [31:0] d, input logic [31:0] e, input logic m);
        set_bus(a, c, d, 1'b1);
        push_exp(n, e, m);
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        bus.DMWr = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        set_bus(32'h0, 3'b010, 32'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        do_load("rst_lw_0",    32'h0,   3'b010, 32'h0);
        do_load("rst_lw_4",    32'h4,   3'b010, 32'h0);
        do_load("rst_lw_ffc",  32'hFFC, 3'b010, 32'h0);
        do_load("rst_lbu_7",   32'h7,   3'b100, 32'h0);

        // Word store and sub-word loads
        do_store(32'h0, 3'b010, 32'hDEADBEEF);
        do_load("lw_0",     32'h0, 3'b010, 32'hDEADBEEF);
        do_load("lbu_3",    32'h3, 3'b100, 32'h000000DE);
        do_load("lb_0",     32'h0, 3'b000, 32'hFFFFFFEF);
        do_load("lh_2",     32'h2, 3'b001, 32'hFFFFDEAD);
        do_load("lhu_0",    32'h0, 3'b101, 32'h0000BEEF);
        do_load("lb_1",     32'h1, 3'b000, 32'hFFFFFFBE);
        do_load("ctl110_0", 32'h0, 3'b110, 32'hDEADBEEF);
        do_load("ctl011_0", 32'h0, 3'b011, 32'h0);
        do_load("ctl111_0", 32'h0, 3'b111, 32'h0);

        // Half stores: upper DataWr bits ignored, other half untouched
        do_store(32'h8, 3'b001, 32'h1234ABCA);
        do_load("lh_8",  32'h8, 3'b001, 32'hFFFFABCA);
        do_load("lhu_8", 32'h8, 3'b101, 32'h0000ABCA);
        do_load("lw_8",  32'h8, 3'b010, 32'h0000ABCA);
        do_store(32'hA, 3'b001, 32'h00007FFF);
        do_load("lw_8_both", 32'h8, 3'b010, 32'h7FFFABCA);
        do_load("lh_a",      32'hA, 3'b001, 32'h00007FFF);

        // Byte stores
        do_store(32'h10, 3'b000, 32'h00000080);
        do_load("lb_10",  32'h10, 3'b000, 32'hFFFFFF80);
        do_load("lbu_10", 32'h10, 3'b100, 32'h00000080);
        do_store(32'h11, 3'b000, 32'h00000055);
        do_load("lw_10", 32'h10, 3'b010, 32'h00005580);
        do_store(32'h13, 3'b100, 32'hFFFFFFAA);
        do_load("lw_10_sbu", 32'h10, 3'b010, 32'hAA005580);

        // Read during write shows old data, new data after the edge
        do_store(32'h20, 3'b010, 32'h55556666);
        do_store_chk("rdw_old", 32'h20, 3'b010, 32'h11112222, 32'h55556666, 1'b0);
        do_load("rdw_new", 32'h20, 3'b010, 32'h11112222);

        // Write disabled and size-11 stores leave memory alone
        do_store(32'h4, 3'b010, 32'hCAFEF00D);
        set_bus(32'h4, 3'b010, 32'h12345678, 1'b0);
        @(posedge clk);
        #1;
        do_load("dmwr0_keep", 32'h4, 3'b010, 32'hCAFEF00D);
        do_store(32'h4, 3'b011, 32'hFFFFFFFF);
        do_load("sz11_keep", 32'h4, 3'b010, 32'hCAFEF00D);

        // Address aliasing modulo 4 KiB
        do_store(32'h1000, 3'b010, 32'h0BADC0DE);
        do_load("alias_0",      32'h0,      3'b010, 32'h0BADC0DE);
        do_load("alias_hi",     32'hFFFF1004, 3'b010, 32'hCAFEF00D);

`ifdef DMEM_MISALIGN_CHECK_EN
        // Misaligned accesses: flagged, store suppressed, DataRd forced to 0
        do_store_chk("mis_sw_2", 32'h2, 3'b010, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_load("mis_sw_kept", 32'h0, 3'b010, 32'h0BADC0DE);
        do_load("mis_lh_9",    32'h9, 3'b001, 32'h0, 1'b1);
        do_load("mis_lw_1",    32'h1, 3'b010, 32'h0, 1'b1);
        do_load("mis_lb_9_ok", 32'h9, 3'b100, 32'h000000AB);
`endif

        // Reset wins over a simultaneous store and clears everything
        set_bus(32'h0, 3'b010, 32'h12345678, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.DMWr = 1'b0;
        do_load("rst_wr_0",  32'h0,  3'b010, 32'h0);
        do_load("rst_wr_10", 32'h10, 3'b010, 32'h0);
        do_load("rst_wr_lb", 32'h8,  3'b000, 32'h0);

        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
